mem_cache: RTL and testbench
============================

MEM_CACHE -- requirements
Module: mem_cache

Interface
REQ-001 Parameters (name, default, meaning):
- addr_width, 32, byte-address width
- data_width, 32, word width
- num_lines, 16, direct-mapped lines, power of 2, min 2
REQ-002 Ports (name direction width meaning):
- clk  in  1  single clock; all logic on posedge clk
- rst  in  1  reset; synchronous, active-high
- core_rd_req  in  1  core read request
- core_wr_req  in  1  core write request
- core_addr  in  addr_width  byte address
- core_wr_data  in  data_width  write data
- core_rd_data  out  data_width  read data, valid only while core_ack=1
- core_busy  out  1  request in progress
- core_ack  out  1  one-cycle completion pulse
- mem_rd_req  out  1  downstream read request, one-cycle pulse
- mem_wr_req  out  1  downstream write request, one-cycle pulse
- mem_addr  out  addr_width  downstream byte address
- mem_wr_data  out  data_width  downstream write data
- mem_rd_data  in  data_width  downstream read data, valid while mem_ack=1
- mem_busy  in  1  downstream busy
- mem_ack  in  1  downstream one-cycle completion pulse

Function
REQ-003 Direct-mapped, write-through, no write-allocate, one word per line.
REQ-004 Address decode:
- addr[1:0] ignored for lookup
- index = addr[2 +: log2(num_lines)]
- tag = remaining upper bits
REQ-005 Per line: valid bit, tag, data word.
REQ-006 FSM states: IDLE, RD_MISS, WR_THRU, RESP.
REQ-007 Requests are sampled only in IDLE; requests arriving in any other state are ignored, not queued.
REQ-008 core_rd_req and core_wr_req both high in IDLE -> write serviced; read dropped.
REQ-009 Read hit at cycle T:
- core_ack=1 and core_rd_data = line data at T+1
- no downstream request
- FSM stays in IDLE
REQ-010 Read miss at cycle T:
- at T+1: mem_rd_req=1 for one cycle, mem_addr = full core_addr; FSM -> RD_MISS; core_busy=1
REQ-011 In RD_MISS, on the cycle mem_ack=1:
- line filled: valid=1, tag, data = mem_rd_data
- FSM -> RESP
REQ-012 Write at cycle T (hit or miss):
- at T+1: mem_wr_req=1 for one cycle, mem_addr = core_addr, mem_wr_data = core_wr_data; FSM -> WR_THRU
- hit: line data updated at T+1
- miss: line state unchanged
REQ-013 In WR_THRU, mem_ack=1 -> FSM -> RESP.
REQ-014 RESP lasts one cycle:
- core_ack=1, core_busy=0
- after read: core_rd_data = filled word
- after write: core_rd_data = 0
- FSM -> IDLE
REQ-015 core_rd_data = 0 whenever core_ack=0.
REQ-016 core_busy=1 from the cycle after a miss or write is accepted until the cycle before RESP, inclusive; 0 otherwise.
REQ-017 A downstream request is never issued while mem_busy=1 or while a previous downstream request is outstanding.
REQ-018 mem_ack in IDLE or RESP is ignored.
REQ-019 mem_addr and mem_wr_data are held stable from issue until mem_ack.
REQ-020 All outputs are registered.

Reset
REQ-021 rst=1 at a clock edge clears:
- all valid bits
- FSM -> IDLE
- every output = 0
REQ-022 Reset mid-operation:
- pending transaction abandoned; no core_ack issued for it
- a late mem_ack after reset is ignored
REQ-023 Requests presented while rst=1 are ignored.

Verification
REQ-024 Scenarios (downstream latency 5 cycles):
- Cold read 0x40 (mem word 0x40 = 0xDEAD0001) -> mem_rd_req pulse at T+1; core_ack with 0xDEAD0001 one cycle after mem_ack.
- Repeat read 0x40 -> core_ack at T+1 with 0xDEAD0001; no mem_rd_req.
- Write 0x40 = 0x12345678 (hit), then read 0x40 -> one mem_wr_req; read hits, returns 0x12345678.
- Read 0x40, then read 0x80 (same index, num_lines=16), then read 0x40 -> each read misses; 0x80 evicts 0x40.
- Simultaneous rd+wr to 0x10 -> only mem_wr_req issued; single core_ack; extra requests during core_busy produce no acks.
- rst asserted in RD_MISS, mem_ack arrives afterwards -> no core_ack; next read of the same address misses.

Source files
------------

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, no-write-allocate cache holding one word per line.
// It sits between a simple core request port and a downstream pulse/ack memory port.
module mem_cache #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int num_lines  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_rd_req,
    input  logic                  core_wr_req,
    input  logic [addr_width-1:0] core_addr,
    input  logic [data_width-1:0] core_wr_data,
    output logic [data_width-1:0] core_rd_data,
    output logic                  core_busy,
    output logic                  core_ack,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wr_data,
    input  logic [data_width-1:0] mem_rd_data,
    input  logic                  mem_busy,
    input  logic                  mem_ack,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = $clog2(num_lines);
    localparam int TAG_W = addr_width - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [num_lines-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [num_lines];
    logic [data_width-1:0] r_data [num_lines];

    // r_need_issue: accepted but downstream was busy, request not yet sent.
    // r_wait_ack:   request sent, only now is mem_ack meaningful.
    logic r_need_issue;
    logic r_wait_ack;

    logic [IDX_W-1:0]      w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_fill_index;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_fill;
    logic                  w_wr_update;

    logic                  w_core_ack_next;
    logic [data_width-1:0] w_core_rd_data_next;
    logic                  w_core_busy_next;
    logic                  w_mem_rd_req_next;
    logic                  w_mem_wr_req_next;
    logic [addr_width-1:0] w_mem_addr_next;
    logic [data_width-1:0] w_mem_wr_data_next;
    logic                  w_need_issue_next;
    logic                  w_wait_ack_next;

    assign w_index      = core_addr[2 +: IDX_W];
    assign w_tag        = core_addr[addr_width-1 -: TAG_W];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // mem_addr is held from issue to ack, so it also names the line being filled
    assign w_fill_index = mem_addr[2 +: IDX_W];
    assign w_fill_tag   = mem_addr[addr_width-1 -: TAG_W];
    assign dbg_state    = r_state;

    always_comb begin
        w_state_next        = r_state;
        w_core_ack_next     = 1'b0;
        w_core_rd_data_next = '0;
        w_core_busy_next    = core_busy;
        w_mem_rd_req_next   = 1'b0;
        w_mem_wr_req_next   = 1'b0;
        w_mem_addr_next     = mem_addr;
        w_mem_wr_data_next  = mem_wr_data;
        w_need_issue_next   = r_need_issue;
        w_wait_ack_next     = r_wait_ack;
        w_fill              = 1'b0;
        w_wr_update         = 1'b0;
        case (r_state)
            IDLE: begin
                // a write wins over a simultaneous read; the read is dropped
                if (core_wr_req) begin
                    w_state_next       = WR_THRU;
                    w_core_busy_next   = 1'b1;
                    w_mem_addr_next    = core_addr;
                    w_mem_wr_data_next = core_wr_data;
                    w_wr_update        = w_hit;
                    w_mem_wr_req_next  = !mem_busy;
                    w_wait_ack_next    = !mem_busy;
                    w_need_issue_next  = mem_busy;
                end else if (core_rd_req) begin
                    if (w_hit) begin
                        w_core_ack_next     = 1'b1;
                        w_core_rd_data_next = r_data[w_index];
                    end else begin
                        w_state_next      = RD_MISS;
                        w_core_busy_next  = 1'b1;
                        w_mem_addr_next   = core_addr;
                        w_mem_rd_req_next = !mem_busy;
                        w_wait_ack_next   = !mem_busy;
                        w_need_issue_next = mem_busy;
                    end
                end
            end
            RD_MISS: begin
                if (r_need_issue && !mem_busy) begin
                    w_mem_rd_req_next = 1'b1;
                    w_need_issue_next = 1'b0;
                    w_wait_ack_next   = 1'b1;
                end else if (r_wait_ack && mem_ack) begin
                    w_fill              = 1'b1;
                    w_state_next        = RESP;
                    w_core_ack_next     = 1'b1;
                    w_core_rd_data_next = mem_rd_data;
                    w_core_busy_next    = 1'b0;
                    w_wait_ack_next     = 1'b0;
                end
            end
            WR_THRU: begin
                if (r_need_issue && !mem_busy) begin
                    w_mem_wr_req_next = 1'b1;
                    w_need_issue_next = 1'b0;
                    w_wait_ack_next   = 1'b1;
                end else if (r_wait_ack && mem_ack) begin
                    w_state_next     = RESP;
                    w_core_ack_next  = 1'b1;
                    w_core_busy_next = 1'b0;
                    w_wait_ack_next  = 1'b0;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_need_issue <= 1'b0;
            r_wait_ack   <= 1'b0;
            core_ack     <= 1'b0;
            core_rd_data <= '0;
            core_busy    <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_need_issue <= w_need_issue_next;
            r_wait_ack   <= w_wait_ack_next;
            core_ack     <= w_core_ack_next;
            core_rd_data <= w_core_rd_data_next;
            core_busy    <= w_core_busy_next;
            mem_rd_req   <= w_mem_rd_req_next;
            mem_wr_req   <= w_mem_wr_req_next;
            mem_addr     <= w_mem_addr_next;
            mem_wr_data  <= w_mem_wr_data_next;
        end
    end

    // Tag and data need no reset: a line is only ever read behind its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_index] <= 1'b1;
            r_tag[w_fill_index]   <= w_fill_tag;
            r_data[w_fill_index]  <= mem_rd_data;
        end else if (w_wr_update) begin
            r_data[w_index] <= core_wr_data;
        end
    end

endmodule

// File: tb/tb_mem_cache.sv
// Randomized scoreboard bench for mem_cache: a word-level cache/memory reference model
// predicts each completion, a monitor checks every core_ack and downstream request.
module tb_mem_cache;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_rd_req = 1'b0;
    logic          core_wr_req = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wr_data = '0;
    logic [DW-1:0] core_rd_data;
    logic          core_busy;
    logic          core_ack;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_busy = 1'b0;
    logic          mem_ack = 1'b0;
    logic [1:0]    dbg_state;

    mem_cache #(.addr_width(AW), .data_width(DW), .num_lines(NL)) dut (
        .clk(clk), .rst(rst),
        .core_rd_req(core_rd_req), .core_wr_req(core_wr_req),
        .core_addr(core_addr), .core_wr_data(core_wr_data),
        .core_rd_data(core_rd_data), .core_busy(core_busy), .core_ack(core_ack),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_busy(mem_busy), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 = hit (no downstream), 1 = downstream read, 2 = downstream write
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    // reference: word-addressed memory and a per-line view of the cache
    logic [DW-1:0] ref_mem [int unsigned];
    logic [DW-1:0] dn_mem  [int unsigned];
    bit            mdl_valid [NL];
    logic [AW-1:0] mdl_tag   [NL];
    logic [DW-1:0] mdl_data  [NL];

    function automatic logic [DW-1:0] mem_default(input int unsigned w);
        return w * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
        int unsigned w = a >> 2;
        if (ref_mem.exists(w)) return ref_mem[w];
        return mem_default(w);
    endfunction

    function automatic logic [DW-1:0] dn_get(input logic [AW-1:0] a);
        int unsigned w = a >> 2;
        if (dn_mem.exists(w)) return dn_mem[w];
        return mem_default(w);
    endfunction

    function automatic exp_t predict(input bit rd, input bit wr, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d);
        exp_t e;
        int idx = (a >> 2) % NL;
        logic [AW-1:0] tg = a / (4 * NL);
        e.addr  = a;
        e.wdata = d;
        if (wr) begin
            e.kind  = 2;
            e.rdata = '0;
            ref_mem[a >> 2] = d;
            if (mdl_valid[idx] && mdl_tag[idx] == tg) mdl_data[idx] = d;
        end else if (rd && mdl_valid[idx] && mdl_tag[idx] == tg) begin
            e.kind  = 0;
            e.rdata = mdl_data[idx];
        end else begin
            e.kind  = 1;
            e.rdata = ref_get(a);
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = tg;
            mdl_data[idx]  = e.rdata;
        end
        return e;
    endfunction

    // downstream memory: fixed 5-cycle latency, optional random busy stalls
    bit            stall_en = 1'b0;
    bit            dn_pend  = 1'b0;
    int            dn_cnt   = 0;
    bit            dn_wr;
    logic [AW-1:0] dn_addr;
    logic [DW-1:0] dn_wdata;

    initial forever begin
        @(negedge clk);
        mem_ack     = 1'b0;
        mem_rd_data = $urandom;
        if (dn_pend) begin
            dn_cnt--;
            if (dn_cnt == 0) begin
                mem_ack = 1'b1;
                if (dn_wr) dn_mem[dn_addr >> 2] = dn_wdata;
                else mem_rd_data = dn_get(dn_addr);
                dn_pend = 1'b0;
            end
        end else if (!rst && (mem_rd_req || mem_wr_req)) begin
            dn_pend  = 1'b1;
            dn_cnt   = 5;
            dn_wr    = mem_wr_req;
            dn_addr  = mem_addr;
            dn_wdata = mem_wr_data;
        end
        mem_busy = dn_pend || (stall_en && $urandom_range(0, 3) == 0);
    end

    // values the DUT saw at the last active edge
    logic busy_prev = 1'b0;
    logic ack_prev  = 1'b0;
    initial forever begin
        @(posedge clk);
        busy_prev = mem_busy;
        ack_prev  = mem_ack;
    end

    // monitor / scoreboard
    int            ack_cnt   = 0;
    int            n_req     = 0;
    int            seen_kind = 0;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_wdata;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            n_req     = 0;
            seen_kind = 0;
        end else begin
            if (mem_rd_req || mem_wr_req) begin
                check("dn_req_while_busy", busy_prev, 0);
                check("dn_rd_and_wr", mem_rd_req & mem_wr_req, 0);
                n_req++;
                seen_kind  = mem_wr_req ? 2 : 1;
                seen_addr  = mem_addr;
                seen_wdata = mem_wr_data;
            end
            check("ack_with_busy", core_ack & core_busy, 0);
            if (core_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", core_ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", core_rd_data, e.rdata);
                    check("dn_kind", seen_kind, e.kind);
                    check("dn_count", n_req, (e.kind != 0) ? 1 : 0);
                    if (e.kind != 0) begin
                        check("dn_addr", seen_addr, e.addr);
                        check("ack_after_mem_ack", ack_prev, 1);
                    end
                    if (e.kind == 2) check("dn_wr_data", seen_wdata, e.wdata);
                end
                n_req     = 0;
                seen_kind = 0;
                ack_cnt++;
            end else begin
                check("rd_data_zero_no_ack", core_rd_data, 0);
            end
        end
    end

    // driver tasks: all input changes happen 2 time units after posedge
    task automatic clear_inputs();
        core_rd_req  = 1'b0;
        core_wr_req  = 1'b0;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit spam);
        exp_t e;
        int   target;
        bit   done;
        e = predict(rd, wr, a, d);
        exp_q.push_back(e);
        target       = ack_cnt + 1;
        core_rd_req  = rd;
        core_wr_req  = wr;
        core_addr    = a;
        core_wr_data = d;
        @(posedge clk); #2;
        clear_inputs();
        if (!stall_en) begin
            if (e.kind == 0) begin
                check("hit_ack_next_cycle", core_ack, 1);
            end else begin
                check("busy_after_accept", core_busy, 1);
                check("dn_pulse_next_cycle", (e.kind == 1) ? mem_rd_req : mem_wr_req, 1);
            end
        end
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (ack_cnt >= target) begin
                done = 1'b1;
            end else begin
                if (spam && core_busy) begin
                    core_rd_req  = 1'($urandom_range(0, 1));
                    core_wr_req  = 1'($urandom_range(0, 1));
                    core_addr    = $urandom;
                    core_wr_data = $urandom;
                end else begin
                    clear_inputs();
                end
                @(posedge clk); #2;
            end
        end
        clear_inputs();
        check("ack_within_budget", done, 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_ack"}, core_ack, 0);
        check({tag, "_core_busy"}, core_busy, 0);
        check({tag, "_core_rd_data"}, core_rd_data, 0);
        check({tag, "_mem_rd_req"}, mem_rd_req, 0);
        check({tag, "_mem_wr_req"}, mem_wr_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // reset while a read miss is waiting downstream; the late mem_ack must be ignored
    task automatic reset_mid_miss(input logic [AW-1:0] a);
        core_rd_req = 1'b1;
        core_addr   = a;
        @(posedge clk); #2;
        clear_inputs();
        check("rm_dn_pulse", mem_rd_req, 1);
        repeat (2) begin @(posedge clk); #2; end
        check("rm_busy_before_reset", core_busy, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check_reset_outputs("rm");
        clear_model();
        repeat (12) begin @(posedge clk); #2; end
        check("rm_idle_after_late_ack", dbg_state, 0);
    endtask

    // main stimulus
    initial begin
        logic [AW-1:0] a;
        int op;
        ref_mem[32'h40 >> 2] = 32'hDEAD_0001;
        dn_mem[32'h40 >> 2]  = 32'hDEAD_0001;
        clear_model();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk); #2;

        do_req(1, 0, 32'h40, 0, 0);              // cold miss
        do_req(1, 0, 32'h40, 0, 0);              // hit
        do_req(0, 1, 32'h40, 32'h1234_5678, 0);  // write hit
        do_req(1, 0, 32'h40, 0, 0);              // hit with new data
        do_req(1, 0, 32'h80, 0, 0);              // conflict miss evicts 0x40
        do_req(1, 0, 32'h40, 0, 0);
        do_req(1, 0, 32'h80, 0, 0);
        do_req(0, 1, 32'h1000, 32'hCAFE_0002, 0); // write miss, no allocate
        do_req(1, 0, 32'h1000, 0, 0);
        do_req(1, 1, 32'h10, 32'hA5A5_0003, 1);  // simultaneous rd+wr, extra requests while busy
        do_req(1, 0, 32'h10, 0, 1);
        reset_mid_miss(32'h200);
        do_req(1, 0, 32'h200, 0, 0);
        do_req(1, 0, 32'h40, 0, 0);

        stall_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a  = (AW'($urandom_range(0, 3)) << 6) | (AW'($urandom_range(0, 15)) << 2)
                 | AW'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op < 5)      do_req(1, 0, a, 0, 1'($urandom_range(0, 1)));
            else if (op < 8) do_req(0, 1, a, $urandom, 1'($urandom_range(0, 1)));
            else             do_req(1, 1, a, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        repeat (20) begin @(posedge clk); #2; end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
